fpu_result_checker: RTL and testbench
=====================================

FPU_RESULT_CHECKER -- requirements
Module: fpu_result_checker

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter DEPTH, default 8, expected-result FIFO depth, power of two, >=2.
REQ-004 SHALL have parameter TOL_ULP, default 4, pass tolerance in units-in-last-place, W-1 bits.
REQ-005 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port exp_valid  input  1  expected-result entry offered.
REQ-008 SHALL have port exp_ready  output  1  FIFO can accept entry.
REQ-009 SHALL have port exp_data  input  W  expected result bits.
REQ-010 SHALL have port exp_funct  input  2  operation code tagged with entry.
REQ-011 SHALL have port exp_last  input  1  entry is final vector of test.
REQ-012 SHALL have port finish  input  1  DUT result-valid strobe, one-cycle pulse per result.
REQ-013 SHALL have port o  input  W  DUT result, sampled when finish=1.
REQ-014 SHALL have port err_pulse  output  1  one-cycle mismatch flag.
REQ-015 SHALL have ports err_funct(2), err_exp(W), err_got(W)  output  mismatch record, held until next mismatch.
REQ-016 SHALL have ports vec_count(32), err_count(32)  output  vectors compared / mismatches.
REQ-017 SHALL have port underflow  output  1  sticky: finish seen with FIFO empty.
REQ-018 SHALL have port done  output  1  sticky: last vector compared.

Function
REQ-019 SHALL implement FSM IDLE -> RUN on first accepted entry; RUN -> DONE when the popped entry has exp_last=1; DONE held until reset.
REQ-020 SHALL assert exp_ready = ~full & (state != DONE) & ~last_accepted; entry written when exp_valid & exp_ready.
REQ-021 SHALL pop one FIFO entry per finish pulse in IDLE/RUN; pointers wrap modulo DEPTH; full/empty via one extra pointer bit.
REQ-022 SHALL allow push and pop in the same cycle; occupancy unchanged; push to empty FIFO in same cycle as finish is NOT bypassed (finish sees empty).
REQ-023 SHALL, on finish with FIFO empty, set underflow, not pop, not increment vec_count.
REQ-024 SHALL ignore finish and exp_valid in DONE.
REQ-025 SHALL register the comparison: finish in cycle t -> err_pulse, err_*, counters updated at end of cycle t+1 (latency 1); back-to-back finish pulses supported.
REQ-026 SHALL compare by mapping each value to an ordered integer (sign=0: magnitude+2^(W-1); sign=1: 2^(W-1)-magnitude) and pass if |difference| <= TOL_ULP.
REQ-027 SHALL treat +0 and -0 as equal (difference 0).
REQ-028 SHALL pass when both values are NaN (any payload), fail when exactly one is NaN; infinities compare by REQ-026.
REQ-029 SHALL increment vec_count per comparison, err_count per failure, each saturating at 2^32-1.
REQ-030 SHALL assert done the cycle after the last-flagged comparison's result registers (same cycle as its err_pulse).

Reset
REQ-031 SHALL, on reset, set state=IDLE, FIFO empty, exp_ready=1, err_pulse=0, err_funct/err_exp/err_got=0, vec_count=0, err_count=0, underflow=0, done=0.
REQ-032 SHALL, on reset mid-operation, discard FIFO contents and any in-flight comparison; no err_pulse the following cycle.

Verification
REQ-033 SHALL test: push 3F800000 (1.0), finish with o=3F800000 -> err_pulse=0, vec_count=1 one cycle later.
REQ-034 SHALL test: exp 3F800000, o=3F800005 (5 ULP, TOL_ULP=4) -> err_pulse=1, err_exp=3F800000, err_got=3F800005, err_count=1; o=3F800004 -> pass.
REQ-035 SHALL test: exp 00000000, o=80000000 -> pass; exp 7FC00000, o=7FC00001 -> pass; exp 7FC00000, o=3F800000 -> fail.
REQ-036 SHALL test: push DEPTH entries without finish -> exp_ready=0; simultaneous push+finish when full-1 keeps count; finish on empty FIFO -> underflow=1, vec_count unchanged.
REQ-037 SHALL test: 4 entries, 4th with exp_last=1, 4 finish pulses -> done=1, exp_ready=0, extra finish ignored, vec_count=4.
REQ-038 SHALL test: reset asserted with 3 entries queued and finish in same cycle -> next cycle all outputs at reset values, err_pulse=0.

Source files
------------

// File: rtl/fpu_result_checker.sv
// Scoreboard for an FPU: queues expected results, compares each DUT result
// within an ULP tolerance (NaN-aware, +0 == -0) and keeps pass/fail statistics.
module fpu_result_checker #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DEPTH = 8,
  parameter logic [EXP_W+MAN_W-1:0] TOL_ULP = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [EXP_W+MAN_W:0]   exp_data,
  input  logic [1:0]             exp_funct,
  input  logic                   exp_last,
  input  logic                   finish,
  input  logic [EXP_W+MAN_W:0]   o,
  output logic                   err_pulse,
  output logic [1:0]             err_funct,
  output logic [EXP_W+MAN_W:0]   err_exp,
  output logic [EXP_W+MAN_W:0]   err_got,
  output logic [31:0]            vec_count,
  output logic [31:0]            err_count,
  output logic                   underflow,
  output logic                   done
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = W + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_rd_entry;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_last_accepted;
  logic          r_cmp_valid;
  logic [W-1:0]  r_cmp_got;

  logic          w_empty;
  logic          w_full;
  logic          w_active;
  logic          w_push;
  logic          w_pop;
  logic          w_pop_final;
  logic [AW:0]   w_rd_ptr_inc;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_active     = (r_state != S_DONE);
  assign exp_ready    = ~w_full & w_active & ~r_last_accepted;
  assign w_push       = exp_valid & exp_ready;
  assign w_pop        = finish & w_active & ~w_empty;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  // Once the last entry is accepted no more can enter, so it is the newest one.
  assign w_pop_final  = w_pop & r_last_accepted & (w_rd_ptr_inc == r_wr_ptr);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {exp_last, exp_funct, exp_data};
    end
    if (w_pop) begin
      r_rd_entry <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_last_accepted <= 1'b0;
      r_cmp_valid     <= 1'b0;
      r_cmp_got       <= '0;
      underflow       <= 1'b0;
    end else begin
      r_cmp_valid <= w_pop;
      if (w_pop) begin
        r_cmp_got <= o;
        r_rd_ptr  <= w_rd_ptr_inc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (exp_last) begin
          r_last_accepted <= 1'b1;
        end
      end
      if (finish && w_active && w_empty) begin
        underflow <= 1'b1;
      end
      case (r_state)
        S_IDLE:  if (w_push) r_state <= S_RUN;
        S_RUN:   if (w_pop_final) r_state <= S_DONE;
        default: r_state <= S_DONE;
      endcase
    end
  end

  // Order-preserving integer view of a sign-magnitude float.
  function automatic logic [W-1:0] f_key(input logic [W-1:0] v);
    if (v[W-1]) begin
      f_key = {1'b1, {(W-1){1'b0}}} - {1'b0, v[W-2:0]};
    end else begin
      f_key = {1'b1, v[W-2:0]};
    end
  endfunction

  function automatic logic f_is_nan(input logic [W-1:0] v);
    f_is_nan = (&v[W-2:MAN_W]) & (|v[MAN_W-1:0]);
  endfunction

  logic [W-1:0] w_exp_val;
  logic [1:0]   w_exp_funct;
  logic         w_exp_last;
  logic [W:0]   w_diff;
  logic [W:0]   w_abs_diff;
  logic         w_nan_exp;
  logic         w_nan_got;
  logic         w_fail;

  assign w_exp_val   = r_rd_entry[W-1:0];
  assign w_exp_funct = r_rd_entry[W+1:W];
  assign w_exp_last  = r_rd_entry[W+2];
  assign w_diff      = {1'b0, f_key(w_exp_val)} - {1'b0, f_key(r_cmp_got)};
  assign w_abs_diff  = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
  assign w_nan_exp   = f_is_nan(w_exp_val);
  assign w_nan_got   = f_is_nan(r_cmp_got);

  always_comb begin
    w_fail = 1'b0;
    if (w_nan_exp != w_nan_got) begin
      w_fail = 1'b1;
    end else if (!w_nan_exp) begin
      w_fail = (w_abs_diff > {2'b00, TOL_ULP});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_funct <= '0;
      err_exp   <= '0;
      err_got   <= '0;
      vec_count <= '0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      err_pulse <= r_cmp_valid & w_fail;
      if (r_cmp_valid) begin
        if (vec_count != '1) begin
          vec_count <= vec_count + 32'd1;
        end
        if (w_exp_last) begin
          done <= 1'b1;
        end
        if (w_fail) begin
          err_funct <= w_exp_funct;
          err_exp   <= w_exp_val;
          err_got   <= r_cmp_got;
          if (err_count != '1) begin
            err_count <= err_count + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker with default parameters (binary32, DEPTH 8, 4 ULP).
module tb_fpu_result_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_data;
  logic [1:0]  exp_funct;
  logic        exp_last;
  logic        finish;
  logic [31:0] o;
  logic        err_pulse;
  logic [1:0]  err_funct;
  logic [31:0] err_exp;
  logic [31:0] err_got;
  logic [31:0] vec_count;
  logic [31:0] err_count;
  logic        underflow;
  logic        done;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fpu_result_checker dut (
    .clk       (clk),
    .reset     (reset),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_data  (exp_data),
    .exp_funct (exp_funct),
    .exp_last  (exp_last),
    .finish    (finish),
    .o         (o),
    .err_pulse (err_pulse),
    .err_funct (err_funct),
    .err_exp   (err_exp),
    .err_got   (err_got),
    .vec_count (vec_count),
    .err_count (err_count),
    .underflow (underflow),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] f, input logic l);
    exp_valid = 1'b1;
    exp_data  = d;
    exp_funct = f;
    exp_last  = l;
    step();
    exp_valid = 1'b0;
    exp_last  = 1'b0;
  endtask

  task automatic fin(input logic [31:0] v);
    finish = 1'b1;
    o      = v;
    step();
    finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; exp_valid = 1'b0; exp_data = '0; exp_funct = '0;
    exp_last = 1'b0; finish = 1'b0; o = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_ready", 32'(exp_ready), 1);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_done", 32'(done), 0);

    // exact match, latency of one cycle
    push(32'h3F800000, 2'd0, 1'b0);
    fin(32'h3F800000);
    chk("lat_vec_not_yet", vec_count, 0);
    step();
    chk("match_pulse", 32'(err_pulse), 0);
    chk("match_vec", vec_count, 1);

    // 5 ULP fails, 4 ULP passes
    push(32'h3F800000, 2'd1, 1'b0);
    fin(32'h3F800005);
    step();
    chk("ulp5_pulse", 32'(err_pulse), 1);
    chk("ulp5_exp", err_exp, 32'h3F800000);
    chk("ulp5_got", err_got, 32'h3F800005);
    chk("ulp5_funct", 32'(err_funct), 1);
    chk("ulp5_errcnt", err_count, 1);
    step();
    chk("pulse_one_cycle", 32'(err_pulse), 0);
    chk("record_held", err_got, 32'h3F800005);
    push(32'h3F800000, 2'd0, 1'b0);
    fin(32'h3F800004);
    step();
    chk("ulp4_pulse", 32'(err_pulse), 0);
    chk("ulp4_errcnt", err_count, 1);
    chk("ulp4_vec", vec_count, 3);

    // across zero: keys 2^31+1 vs 2^31-2 (3 ULP), then 2^31+2 vs 2^31-3 (5 ULP)
    push(32'h00000001, 2'd0, 1'b0);
    fin(32'h80000002);
    step();
    chk("cross3_pulse", 32'(err_pulse), 0);
    push(32'h00000002, 2'd2, 1'b0);
    fin(32'h80000003);
    step();
    chk("cross5_pulse", 32'(err_pulse), 1);
    chk("cross5_funct", 32'(err_funct), 2);
    chk("cross5_errcnt", err_count, 2);

    // signed zeros, NaN handling, infinity by ULP
    push(32'h00000000, 2'd0, 1'b0);
    fin(32'h80000000);
    step();
    chk("zeros_pulse", 32'(err_pulse), 0);
    push(32'h7FC00000, 2'd0, 1'b0);
    fin(32'h7FC00001);
    step();
    chk("nan_nan_pulse", 32'(err_pulse), 0);
    push(32'h7FC00000, 2'd3, 1'b0);
    fin(32'h3F800000);
    step();
    chk("nan_num_pulse", 32'(err_pulse), 1);
    chk("nan_num_funct", 32'(err_funct), 3);
    chk("nan_num_errcnt", err_count, 3);
    push(32'h7F800000, 2'd0, 1'b0);
    fin(32'h7F7FFFFF);
    step();
    chk("inf_1ulp_pulse", 32'(err_pulse), 0);
    chk("inf_vec", vec_count, 9);

    // back-to-back finish pulses
    push(32'h3F800000, 2'd0, 1'b0);
    push(32'h3F800000, 2'd0, 1'b0);
    finish = 1'b1; o = 32'h3F800000;
    step();
    o = 32'h40000000;
    step();
    finish = 1'b0;
    chk("b2b_first_pulse", 32'(err_pulse), 0);
    chk("b2b_first_vec", vec_count, 10);
    step();
    chk("b2b_second_pulse", 32'(err_pulse), 1);
    chk("b2b_second_got", err_got, 32'h40000000);
    chk("b2b_vec", vec_count, 11);
    chk("b2b_errcnt", err_count, 4);

    // full FIFO, push+pop together, drain, underflow without bypass
    repeat (8) push(32'h3F800000, 2'd0, 1'b0);
    chk("full_ready", 32'(exp_ready), 0);
    fin(32'h3F800000);
    step();
    chk("after_pop_ready", 32'(exp_ready), 1);
    exp_valid = 1'b1; exp_data = 32'h3F800000; finish = 1'b1; o = 32'h3F800000;
    step();
    exp_valid = 1'b0; finish = 1'b0;
    step();
    chk("pushpop_vec", vec_count, 13);
    chk("pushpop_ready", 32'(exp_ready), 1);
    push(32'h3F800000, 2'd0, 1'b0);
    chk("refull_ready", 32'(exp_ready), 0);
    finish = 1'b1; o = 32'h3F800000;
    repeat (8) @(posedge clk);
    #1;
    finish = 1'b0;
    step();
    chk("drain_vec", vec_count, 21);
    chk("drain_underflow", 32'(underflow), 0);
    exp_valid = 1'b1; exp_data = 32'h3F800000; finish = 1'b1; o = 32'h3F800000;
    step();
    exp_valid = 1'b0; finish = 1'b0;
    step();
    chk("empty_underflow", 32'(underflow), 1);
    chk("empty_vec", vec_count, 21);
    fin(32'h3F800000);
    step();
    chk("nobypass_vec", vec_count, 22);
    chk("nobypass_pulse", 32'(err_pulse), 0);

    // last-flagged run to DONE
    push(32'h3F800000, 2'd0, 1'b0);
    push(32'h3F800000, 2'd0, 1'b0);
    push(32'h3F800000, 2'd0, 1'b0);
    push(32'h40400000, 2'd1, 1'b1);
    chk("last_ready", 32'(exp_ready), 0);
    finish = 1'b1; o = 32'h3F800000;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    o = 32'h40400010;
    step();
    finish = 1'b0;
    chk("done_not_yet", 32'(done), 0);
    chk("done_pre_vec", vec_count, 25);
    step();
    chk("done_set", 32'(done), 1);
    chk("done_pulse", 32'(err_pulse), 1);
    chk("done_errexp", err_exp, 32'h40400000);
    chk("done_vec", vec_count, 26);
    chk("done_errcnt", err_count, 5);
    chk("done_ready", 32'(exp_ready), 0);
    exp_valid = 1'b1; exp_data = 32'h12345678; finish = 1'b1; o = 32'h00000000;
    step();
    exp_valid = 1'b0; finish = 1'b0;
    step();
    chk("done_ignore_vec", vec_count, 26);
    chk("done_ignore_pulse", 32'(err_pulse), 0);
    chk("done_hold", 32'(done), 1);

    // reset mid-operation with finish in the same cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(32'h3F800000, 2'd1, 1'b0);
    push(32'h3F800000, 2'd1, 1'b0);
    push(32'h3F800000, 2'd1, 1'b0);
    reset = 1'b1; finish = 1'b1; o = 32'h12345678;
    step();
    reset = 1'b0; finish = 1'b0;
    chk("mrst_ready", 32'(exp_ready), 1);
    chk("mrst_pulse", 32'(err_pulse), 0);
    chk("mrst_vec", vec_count, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_underflow", 32'(underflow), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_errexp", err_exp, 0);
    chk("mrst_errgot", err_got, 0);
    chk("mrst_funct", 32'(err_funct), 0);
    step();
    chk("mrst_inflight_pulse", 32'(err_pulse), 0);
    chk("mrst_inflight_vec", vec_count, 0);
    fin(32'h3F800000);
    step();
    chk("mrst_fifo_empty", 32'(underflow), 1);
    chk("mrst_fifo_vec", vec_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
